// File: rtl/bp_piso_sched_pkg.sv
// Shared types for the round-robin parallel-in/serial-out message scheduler.
package bp_piso_sched_pkg;

    // Idle: a new grant is chosen every cycle. Busy: a grant is locked mid-message.
    typedef enum logic {
        e_idle = 1'b0,
        e_busy = 1'b1
    } bp_piso_sched_state_e;

endpackage

// File: rtl/bp_rr_select.sv
// Round-robin pick: first asserted request at or after rr_ptr_i, wrapping
// modulo reqs_p. Purely combinational.
module bp_rr_select #(
    parameter int reqs_p     = 2,
    parameter int lg_reqs_lp = (reqs_p > 1) ? $clog2(reqs_p) : 1
) (
    input  logic [reqs_p-1:0]     v_i,
    input  logic [lg_reqs_lp-1:0] rr_ptr_i,
    output logic [reqs_p-1:0]     grant_oh_o,
    output logic [lg_reqs_lp-1:0] grant_idx_o,
    output logic                  any_v_o
);

    // Walk the requesters starting at the pointer; first hit wins.
    always_comb begin
        int   idx;
        logic found;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < reqs_p; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= reqs_p) idx = idx - reqs_p;
            if (!found && v_i[idx]) begin
                found           = 1'b1;
                grant_idx_o     = lg_reqs_lp'(idx);
                grant_oh_o[idx] = 1'b1;
            end
        end
    end

    assign any_v_o = |v_i;

endmodule

// File: rtl/bsg_mux.sv
// Plain N:1 word multiplexer.
module bsg_mux #(
    parameter int width_p   = 1,
    parameter int els_p     = 1,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic [els_p-1:0][width_p-1:0] data_i,
    input  logic [lg_els_lp-1:0]          sel_i,
    output logic [width_p-1:0]            data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/bp_piso_rr_scheduler.sv
// Shares one serializing output channel among reqs_p requesters. A round-robin
// grant is locked for a whole message; words issue one per handshake.
module bp_piso_rr_scheduler
    import bp_piso_sched_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int els_p      = 4,
    parameter int reqs_p     = 3,
    parameter int hi_to_lo_p = 0,
    parameter int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int lg_reqs_lp = (reqs_p > 1) ? $clog2(reqs_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [reqs_p-1:0]                 v_i,
    input  logic [reqs_p*els_p*width_p-1:0]   data_i,
    input  logic [reqs_p*lg_els_lp-1:0]       len_i,
    output logic [reqs_p-1:0]                 ready_and_o,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    output logic [lg_reqs_lp-1:0]             id_o,
    output logic                              last_o,
    input  logic                              ready_and_i
);

    bp_piso_sched_state_e        state_r;
    logic [lg_reqs_lp-1:0]       grant_r;
    logic [lg_els_lp-1:0]        count_r;
    logic [lg_reqs_lp-1:0]       rr_ptr_r;

    logic [els_p-1:0][width_p-1:0] msg_arr [reqs_p];
    logic [lg_els_lp-1:0]          len_arr [reqs_p];
    logic [reqs_p-1:0]             sel_oh, busy_oh, grant_oh;
    logic [lg_reqs_lp-1:0]         sel_idx, grant, ptr_next;
    logic                          any_v, v_int, last, xfer;
    logic [lg_els_lp-1:0]          len_cur, word_idx;
    logic [els_p-1:0][width_p-1:0] msg_sel;
    logic [width_p-1:0]            word;

    // Unpack the flat per-requester buses and build the locked-grant one-hot.
    for (genvar gi = 0; gi < reqs_p; gi++) begin : g_req
        assign msg_arr[gi] = data_i[gi*els_p*width_p +: els_p*width_p];
        assign len_arr[gi] = len_i[gi*lg_els_lp +: lg_els_lp];
        assign busy_oh[gi] = (grant_r == lg_reqs_lp'(gi));
    end

    bp_rr_select #(
        .reqs_p     (reqs_p),
        .lg_reqs_lp (lg_reqs_lp)
    ) u_rr_select (
        .v_i         (v_i),
        .rr_ptr_i    (rr_ptr_r),
        .grant_oh_o  (sel_oh),
        .grant_idx_o (sel_idx),
        .any_v_o     (any_v)
    );

    // Idle picks a fresh grant with zero latency; busy keeps the locked one.
    assign grant    = (state_r == e_idle) ? sel_idx : grant_r;
    assign grant_oh = (state_r == e_idle) ? sel_oh : busy_oh;
    assign v_int    = (state_r == e_idle) ? any_v : v_i[grant_r];
    assign len_cur  = len_arr[grant];
    assign last     = (els_p == 1) ? 1'b1 : (count_r == len_cur);
    assign word_idx = (els_p == 1) ? '0
                    : (hi_to_lo_p != 0) ? (len_cur - count_r) : count_r;
    assign msg_sel  = msg_arr[grant];
    assign xfer     = v_int & ready_and_i;
    assign ptr_next = (grant == lg_reqs_lp'(reqs_p - 1)) ? '0 : grant + 1'b1;

    bsg_mux #(
        .width_p   (width_p),
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) u_word_mux (
        .data_i (msg_sel),
        .sel_i  (word_idx),
        .data_o (word)
    );

    // Outputs are forced quiet while reset is held, independent of v_i.
    assign v_o         = reset_n_i & v_int;
    assign data_o      = word;
    assign id_o        = reset_n_i ? grant : '0;
    assign last_o      = reset_n_i & last;
    assign ready_and_o = (reset_n_i && xfer && last) ? grant_oh : '0;

    // Message state machine: lock grant on a non-last word, release on the last.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            grant_r  <= '0;
            count_r  <= '0;
            rr_ptr_r <= '0;
        end else if (xfer) begin
            if (last) begin
                state_r  <= e_idle;
                count_r  <= '0;
                rr_ptr_r <= ptr_next;
            end else begin
                state_r  <= e_busy;
                grant_r  <= grant;
                count_r  <= count_r + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    logic [els_p-1:0][width_p-1:0] held_data_r;
    logic [lg_els_lp-1:0]          held_len_r;

    // Remember the granted message as its words start flowing.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && xfer && !last) begin
            held_data_r <= msg_arr[grant];
            held_len_r  <= len_cur;
        end
    end

    // A requester mid-message must keep its request and message stable.
    always @(negedge clk_i) begin
        if (reset_n_i && state_r == e_busy) begin
            assert (v_i[grant_r])
                else $error("requester %0d dropped v_i mid-message", grant_r);
            assert (msg_arr[grant_r] == held_data_r)
                else $error("requester %0d changed data_i mid-message", grant_r);
            assert (len_arr[grant_r] == held_len_r)
                else $error("requester %0d changed len_i mid-message", grant_r);
        end
    end

    // Length must address a real word; only expressible when els_p is not a power of 2.
    if ((1 << lg_els_lp) != els_p) begin : g_len_chk
        for (genvar gi = 0; gi < reqs_p; gi++) begin : g_len
            always @(negedge clk_i) begin
                if (reset_n_i && v_i[gi]) begin
                    assert (int'(len_arr[gi]) <= els_p - 1)
                        else $error("requester %0d len_i out of range", gi);
                end
            end
        end
    end
`endif

endmodule
